// File: rtl/branch_ctrl.sv
// branch_ctrl: multi-cycle conditional-branch resolution controller.
// Accepts one branch from decode, drives the shared comparator for one cycle,
// decodes funct3 into a taken decision and returns the next PC to fetch.
// Optional macro BRANCH_CTRL_STATS_EN adds saturating branch statistics counters.
module branch_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic [XLEN-1:0] cmp_rs1_o,
    output logic [XLEN-1:0] cmp_rs2_o,
    output logic            br_unsigned_o,
    input  logic            br_less_i,
    input  logic            br_equal_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic            taken_o,
    output logic [XLEN-1:0] next_pc_o,
    output logic            flush_o,
    output logic            illegal_o,
`ifdef BRANCH_CTRL_STATS_EN
    output logic [31:0]     br_total_o,
    output logic [31:0]     br_taken_o,
`endif
    output logic            misalign_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t          state_q, state_d;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] pc_q, imm_q, rs1_q, rs2_q;
    logic            taken_q, illegal_q, misalign_q;
    logic [XLEN-1:0] next_pc_q;

    logic            taken_d, illegal_d;
    logic [XLEN-1:0] target, fallthrough;

    // Status and comparator drive come straight from the state and latched operands;
    // a reset in flight suppresses the response so an aborted branch never handshakes.
    assign req_ready_o   = (state_q == IDLE);
    assign cmp_rs1_o     = rs1_q;
    assign cmp_rs2_o     = rs2_q;
    assign br_unsigned_o = (state_q != IDLE) && funct3_q[1];
    assign rsp_valid_o   = (state_q == RESP) && !rst_i;
    assign flush_o       = rsp_valid_o && rsp_ready_i && taken_q;
    assign taken_o       = taken_q;
    assign next_pc_o     = next_pc_q;
    assign illegal_o     = illegal_q;
    assign misalign_o    = misalign_q;

    assign target        = pc_q + imm_q;
    assign fallthrough   = pc_q + PC_STEP;

    // Decode funct3 against the comparator results into a taken/illegal decision.
    always_comb begin
        taken_d   = 1'b0;
        illegal_d = 1'b0;
        case (funct3_q)
            3'b000:         taken_d = br_equal_i;
            3'b001:         taken_d = !br_equal_i;
            3'b100, 3'b110: taken_d = br_less_i;
            3'b101, 3'b111: taken_d = !br_less_i;
            default:        illegal_d = 1'b1;
        endcase
    end

    // Next-state logic: accept in IDLE, one compare cycle, then hold until fetch accepts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = CMP;
            CMP:     state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register, operand latch and registered resolution result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            funct3_q   <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            taken_q    <= 1'b0;
            illegal_q  <= 1'b0;
            misalign_q <= 1'b0;
            next_pc_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid_i) begin
                funct3_q <= funct3_i;
                pc_q     <= pc_i;
                imm_q    <= imm_i;
                rs1_q    <= rs1_data_i;
                rs2_q    <= rs2_data_i;
            end
            if (state_q == CMP) begin
                taken_q    <= taken_d;
                illegal_q  <= illegal_d;
                misalign_q <= taken_d && (target[1:0] != 2'b00);
                next_pc_q  <= taken_d ? target : fallthrough;
            end
        end
    end

`ifdef BRANCH_CTRL_STATS_EN
    logic [31:0] total_q, taken_cnt_q;
    logic        handshake;

    assign handshake  = (state_q == RESP) && rsp_ready_i;
    assign br_total_o = total_q;
    assign br_taken_o = taken_cnt_q;

    // Saturating counters of completed and taken responses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            total_q     <= '0;
            taken_cnt_q <= '0;
        end else if (handshake) begin
            if (total_q != 32'hFFFF_FFFF)
                total_q <= total_q + 32'd1;
            if (taken_q && taken_cnt_q != 32'hFFFF_FFFF)
                taken_cnt_q <= taken_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed self-checking bench for branch_ctrl.
// Models the shared comparator and walks hand-computed branch vectors through
// the request / compare / response sequence, including backpressure and reset abort.
module tb_branch_ctrl;

    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            req_valid_i;
    logic            req_ready_o;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] pc_i, imm_i, rs1_data_i, rs2_data_i;
    logic [XLEN-1:0] cmp_rs1_o, cmp_rs2_o;
    logic            br_unsigned_o;
    logic            br_less_i, br_equal_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic            taken_o;
    logic [XLEN-1:0] next_pc_o;
    logic            flush_o, illegal_o, misalign_o;
`ifdef BRANCH_CTRL_STATS_EN
    logic [31:0]     br_total_o, br_taken_o;
`endif

    int tests    = 0;
    int failures = 0;

    branch_ctrl #(.XLEN(XLEN), .RESET_PC(32'h0000_0000)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .funct3_i     (funct3_i),
        .pc_i         (pc_i),
        .imm_i        (imm_i),
        .rs1_data_i   (rs1_data_i),
        .rs2_data_i   (rs2_data_i),
        .cmp_rs1_o    (cmp_rs1_o),
        .cmp_rs2_o    (cmp_rs2_o),
        .br_unsigned_o(br_unsigned_o),
        .br_less_i    (br_less_i),
        .br_equal_i   (br_equal_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .taken_o      (taken_o),
        .next_pc_o    (next_pc_o),
        .flush_o      (flush_o),
        .illegal_o    (illegal_o),
`ifdef BRANCH_CTRL_STATS_EN
        .br_total_o   (br_total_o),
        .br_taken_o   (br_taken_o),
`endif
        .misalign_o   (misalign_o)
    );

    // Free-running clock, 10 ns period.
    always #5 clk_i = ~clk_i;

    // Shared comparator model: combinational on the controller's comparator outputs.
    always_comb begin
        br_equal_i = (cmp_rs1_o == cmp_rs2_o);
        if (br_unsigned_o)
            br_less_i = (cmp_rs1_o < cmp_rs2_o);
        else
            br_less_i = ($signed(cmp_rs1_o) < $signed(cmp_rs2_o));
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present a request in an IDLE cycle and check it is offered ready.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [31:0] rs1, input logic [31:0] rs2);
        req_valid_i = 1'b1;
        funct3_i    = f3;
        pc_i        = pc;
        imm_i       = imm;
        rs1_data_i  = rs1;
        rs2_data_i  = rs2;
        #1;
        checkOutput("req_ready_idle", 32'(req_ready_o), 32'd1);
    endtask

    // Run one branch end to end: accept, compare cycle, optional backpressure, handshake.
    task automatic runBranch(input string name, input logic [2:0] f3, input logic [31:0] pc,
                             input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic exp_taken, input logic [31:0] exp_pc,
                             input logic exp_illegal, input logic exp_misalign, input int hold);
        applyStimulus(f3, pc, imm, rs1, rs2);
        tick();
        req_valid_i = 1'b0;
        rs1_data_i  = $urandom;
        rs2_data_i  = $urandom;
        pc_i        = $urandom;
        #1;
        checkOutput({name, "_cmp_ready"},    32'(req_ready_o),   32'd0);
        checkOutput({name, "_cmp_valid"},    32'(rsp_valid_o),   32'd0);
        checkOutput({name, "_cmp_unsigned"}, 32'(br_unsigned_o), 32'(f3[1]));
        checkOutput({name, "_cmp_rs1"},      cmp_rs1_o,          rs1);
        checkOutput({name, "_cmp_rs2"},      cmp_rs2_o,          rs2);
        tick();
        for (int i = 0; i < hold; i++) begin
            rsp_ready_i = 1'b0;
            req_valid_i = 1'b1;
            #1;
            checkOutput({name, "_hold_valid"},  32'(rsp_valid_o),   32'd1);
            checkOutput({name, "_hold_ready"},  32'(req_ready_o),   32'd0);
            checkOutput({name, "_hold_flush"},  32'(flush_o),       32'd0);
            checkOutput({name, "_hold_nextpc"}, next_pc_o,          exp_pc);
            checkOutput({name, "_hold_unsig"},  32'(br_unsigned_o), 32'(f3[1]));
            tick();
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        #1;
        checkOutput({name, "_rsp_valid"},    32'(rsp_valid_o), 32'd1);
        checkOutput({name, "_taken"},        32'(taken_o),     32'(exp_taken));
        checkOutput({name, "_next_pc"},      next_pc_o,        exp_pc);
        checkOutput({name, "_illegal"},      32'(illegal_o),   32'(exp_illegal));
        checkOutput({name, "_misalign"},     32'(misalign_o),  32'(exp_misalign));
        checkOutput({name, "_flush"},        32'(flush_o),     32'(exp_taken));
        tick();
        rsp_ready_i = 1'b0;
        #1;
        checkOutput({name, "_post_valid"},   32'(rsp_valid_o), 32'd0);
        checkOutput({name, "_post_flush"},   32'(flush_o),     32'd0);
        checkOutput({name, "_post_ready"},   32'(req_ready_o), 32'd1);
        checkOutput({name, "_post_next_pc"}, next_pc_o,        exp_pc);
    endtask

    // Directed sequence of branch vectors with hand-computed results.
    initial begin
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        funct3_i    = 3'b000;
        pc_i        = '0;
        imm_i       = '0;
        rs1_data_i  = '0;
        rs2_data_i  = '0;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        checkOutput("reset_ready",    32'(req_ready_o), 32'd1);
        checkOutput("reset_valid",    32'(rsp_valid_o), 32'd0);
        checkOutput("reset_next_pc",  next_pc_o,        32'h0000_0000);
        checkOutput("reset_taken",    32'(taken_o),     32'd0);
        checkOutput("reset_flush",    32'(flush_o),     32'd0);
        checkOutput("reset_cmp_rs1",  cmp_rs1_o,        32'h0);
        tick();

        runBranch("beq_taken",  3'b000, 32'h0000_0100, 32'h0000_0020, 32'd5,         32'd5,         1'b1, 32'h0000_0120, 1'b0, 1'b0, 0);
        runBranch("blt_signed", 3'b100, 32'h0000_0200, 32'h0000_0040, 32'hFFFF_FFFF, 32'd1,         1'b1, 32'h0000_0240, 1'b0, 1'b0, 0);
        runBranch("bltu_ntkn",  3'b110, 32'h0000_0200, 32'h0000_0040, 32'hFFFF_FFFF, 32'd1,         1'b0, 32'h0000_0204, 1'b0, 1'b0, 0);
        runBranch("bne_hold",   3'b001, 32'h0000_0300, 32'hFFFF_FFF0, 32'd3,         32'd4,         1'b1, 32'h0000_02F0, 1'b0, 1'b0, 5);
        runBranch("illegal",    3'b010, 32'h0000_0400, 32'h0000_0008, 32'd1,         32'd1,         1'b0, 32'h0000_0404, 1'b1, 1'b0, 0);
        runBranch("bge_wrap",   3'b101, 32'hFFFF_FFF0, 32'h0000_0020, 32'd7,         32'hFFFF_FFFE, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 0);
        runBranch("bgeu_ntkn",  3'b111, 32'h0000_0500, 32'h0000_0020, 32'd1,         32'hFFFF_FFFE, 1'b0, 32'h0000_0504, 1'b0, 1'b0, 0);
        runBranch("beq_mis",    3'b000, 32'h0000_0600, 32'h0000_0006, 32'd9,         32'd9,         1'b1, 32'h0000_0606, 1'b0, 1'b1, 0);
`ifdef BRANCH_CTRL_STATS_EN
        checkOutput("stats_total", br_total_o, 32'd8);
        checkOutput("stats_taken", br_taken_o, 32'd5);
`endif

        // Reset while a taken response is pending must abort it without a flush.
        applyStimulus(3'b000, 32'h0000_0700, 32'h0000_0010, 32'd2, 32'd2);
        tick();
        req_valid_i = 1'b0;
        tick();
        rsp_ready_i = 1'b1;
        rst_i       = 1'b1;
        #1;
        checkOutput("abort_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("abort_flush", 32'(flush_o),     32'd0);
        tick();
        rst_i       = 1'b0;
        rsp_ready_i = 1'b0;
        #1;
        checkOutput("abort_ready",    32'(req_ready_o),   32'd1);
        checkOutput("abort_rvalid",   32'(rsp_valid_o),   32'd0);
        checkOutput("abort_taken",    32'(taken_o),       32'd0);
        checkOutput("abort_next_pc",  next_pc_o,          32'h0000_0000);
        checkOutput("abort_misalign", 32'(misalign_o),    32'd0);
        checkOutput("abort_unsigned", 32'(br_unsigned_o), 32'd0);
        checkOutput("abort_cmp_rs1",  cmp_rs1_o,          32'h0);
`ifdef BRANCH_CTRL_STATS_EN
        checkOutput("abort_stats_total", br_total_o, 32'd0);
`endif

        runBranch("bltu_taken", 3'b110, 32'h0000_0800, 32'h0000_0100, 32'd1, 32'hFFFF_FFFE, 1'b1, 32'h0000_0900, 1'b0, 1'b0, 0);
`ifdef BRANCH_CTRL_STATS_EN
        checkOutput("final_stats_total", br_total_o, 32'd1);
        checkOutput("final_stats_taken", br_taken_o, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
